// File: rtl/dist_mem_pkg.sv
// Shared types and helpers for the multi-port distributed memory.
// The byte merge works at a fixed maximum width; callers cast in and out.
package dist_mem_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} mem_state_t;

  localparam int unsigned MAX_W     = 1024;
  localparam int unsigned MAX_LANES = MAX_W / 8;

  function automatic int unsigned num_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_W-1:0] merge(
    input logic [MAX_W-1:0]     old_word,
    input logic [MAX_W-1:0]     new_word,
    input logic [MAX_LANES-1:0] strb
  );
    logic [MAX_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dist_mem_rd_port.sv
// One read port: range check, busy masking, write-first forwarding and an
// optional output register.
module dist_mem_rd_port
  import dist_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned REG_OUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busy,
  input  logic                  wr_ok,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     arr_word,
  output logic [DATA_W-1:0]     data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              valid;
  logic              hit;
  logic [DATA_W-1:0] fwd_word;
  logic [DATA_W-1:0] q;

  assign valid = !busy && ({1'b0, addr} < DEPTH_L);
  assign hit   = wr_ok && (addr == wr_addr);

  assign fwd_word = hit
    ? DATA_W'(merge(MAX_W'(arr_word), MAX_W'(wr_data), MAX_LANES'(wr_strb)))
    : arr_word;

  // The register exists in both modes so every input has a reader; it is
  // left unconnected (and trimmed) when the combinational path is selected.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= valid ? fwd_word : '0;
  end

  assign data = (REG_OUT != 0) ? q : (valid ? arr_word : '0);

endmodule

// File: rtl/dist_mem_mport.sv
// Distributed RAM with one byte-strobed write port, NUM_RD read ports and a
// post-reset clear sweep.
module dist_mem_mport
  import dist_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned REG_OUT      = 0,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         a,
  input  logic [DATA_W-1:0]         d,
  input  logic [DATA_W/8-1:0]       wstrb,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic                      busy,
  output logic                      wr_err
);

  localparam int unsigned     LANES   = num_lanes(DATA_W);
  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_t      state, state_nx;
  logic [ADDR_W:0] clr_cnt, clr_cnt_nx;
  logic            wr_ok;

  assign busy  = (state == ST_CLEAR);
  assign wr_ok = we && !rst && (state == ST_READY) && ({1'b0, a} < DEPTH_L);

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_nx = clr_cnt + 1'b1;
      if (clr_cnt == LAST) state_nx = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
      wr_err  <= we && !wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_cnt[IDX_W-1:0]] <= '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[a[IDX_W-1:0]][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DATA_W-1:0] arr_word;
    assign arr_word = mem[rd_addr[k*ADDR_W +: IDX_W]];

    dist_mem_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .REG_OUT (REG_OUT)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .wr_ok    (wr_ok),
      .wr_addr  (a),
      .wr_data  (d),
      .wr_strb  (wstrb),
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .arr_word (arr_word),
      .data     (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_dist_mem_mport.sv
// Directed bench for dist_mem_mport: default, registered-read and DEPTH=200
// instances share one stimulus stream.
module tb_dist_mem_mport;

  logic        clk;
  logic        rst;
  logic        we;
  logic [7:0]  a;
  logic [31:0] d;
  logic [3:0]  wstrb;
  logic [15:0] rd_addr;

  logic [63:0] rd0, rd1, rd2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dist_mem_mport u_def (
    .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .wstrb(wstrb),
    .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .wr_err(err0)
  );

  dist_mem_mport #(.REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .wstrb(wstrb),
    .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .wr_err(err1)
  );

  dist_mem_mport #(.DEPTH(200)) u_d200 (
    .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .wstrb(wstrb),
    .rd_addr(rd_addr), .rd_data(rd2), .busy(busy2), .wr_err(err2)
  );

  task automatic test_reset();
    int n0 = 0;
    int n1 = 0;
    int n2 = 0;
    rst = 1'b1; we = 1'b0; a = 8'h05; d = 32'hFFFF_FFFF; wstrb = 4'hF;
    rd_addr = {8'h03, 8'h03};
    @(negedge clk);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", err0); end
    checks++; if (rd1 !== 64'h0) begin failures++; $display("FAIL reset_reg_rd got=%h exp=0", rd1); end
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (busy2) n2++;
      if (i == 11) begin
        checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL busy_write_err got=%b exp=1", err0); end
        checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL busy_write_err_d200 got=%b exp=1", err2); end
      end
      if (i == 12) begin
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL busy_write_err_pulse got=%b exp=0", err0); end
      end
      if (i == 20) begin
        checks++; if (rd0 !== 64'h0) begin failures++; $display("FAIL busy_comb_rd got=%h exp=0", rd0); end
        checks++; if (rd1 !== 64'h0) begin failures++; $display("FAIL busy_reg_rd got=%h exp=0", rd1); end
      end
      we = (i == 10);
      @(negedge clk);
    end
    checks++; if (n0 !== 256) begin failures++; $display("FAIL busy_len got=%0d exp=256", n0); end
    checks++; if (n1 !== 256) begin failures++; $display("FAIL busy_len_reg got=%0d exp=256", n1); end
    checks++; if (n2 !== 200) begin failures++; $display("FAIL busy_len_d200 got=%0d exp=200", n2); end
    rd_addr = {8'h05, 8'h03};
    #1;
    checks++; if (rd0 !== 64'h0) begin failures++; $display("FAIL post_clear_rd got=%h exp=0", rd0); end
  endtask

  task automatic test_strobe();
    @(negedge clk);
    we = 1'b1; a = 8'h01; d = 32'h3DCC_CCCD; wstrb = 4'b1111;
    @(negedge clk);
    d = 32'hAABB_CCDD; wstrb = 4'b0101;
    @(negedge clk);
    we = 1'b0; rd_addr = {8'h00, 8'h01};
    #1;
    checks++; if (rd0[31:0] !== 32'h3DBB_CCDD) begin failures++; $display("FAIL strobe_merge got=%h exp=3dbbccdd", rd0[31:0]); end
    @(negedge clk);
    checks++; if (rd1[31:0] !== 32'h3DBB_CCDD) begin failures++; $display("FAIL strobe_merge_reg got=%h exp=3dbbccdd", rd1[31:0]); end
    we = 1'b1; d = 32'h0; wstrb = 4'b0000;
    @(negedge clk);
    we = 1'b0;
    #1;
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL zero_strb_err got=%b exp=0", err0); end
    checks++; if (rd0[31:0] !== 32'h3DBB_CCDD) begin failures++; $display("FAIL zero_strb_data got=%h exp=3dbbccdd", rd0[31:0]); end
  endtask

  task automatic test_reg_forward();
    @(negedge clk);
    we = 1'b1; a = 8'h11; d = 32'hCAFE_F00D; wstrb = 4'hF;
    @(negedge clk);
    a = 8'h10; d = 32'h1234_5678; rd_addr = {8'h11, 8'h10};
    @(negedge clk);
    we = 1'b0;
    checks++; if (rd1[31:0] !== 32'h1234_5678) begin failures++; $display("FAIL fwd_full got=%h exp=12345678", rd1[31:0]); end
    checks++; if (rd1[63:32] !== 32'hCAFE_F00D) begin failures++; $display("FAIL fwd_other_port got=%h exp=cafef00d", rd1[63:32]); end
    @(negedge clk);
    we = 1'b1; a = 8'h10; d = 32'hFFFF_FFFF; wstrb = 4'hF;
    @(negedge clk);
    d = 32'h1234_5678; wstrb = 4'b0011;
    @(negedge clk);
    we = 1'b0;
    checks++; if (rd1[31:0] !== 32'hFFFF_5678) begin failures++; $display("FAIL fwd_partial got=%h exp=ffff5678", rd1[31:0]); end
    @(negedge clk);
    checks++; if (rd1[31:0] !== 32'hFFFF_5678) begin failures++; $display("FAIL fwd_partial_array got=%h exp=ffff5678", rd1[31:0]); end
  endtask

  task automatic test_comb_read();
    @(negedge clk);
    we = 1'b1; a = 8'h20; d = 32'hDEAD_BEEF; wstrb = 4'hF; rd_addr = {8'h00, 8'h20};
    #1;
    checks++; if (rd0[31:0] !== 32'h0) begin failures++; $display("FAIL comb_before_edge got=%h exp=0", rd0[31:0]); end
    @(posedge clk);
    #1;
    checks++; if (rd0[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL comb_after_edge got=%h exp=deadbeef", rd0[31:0]); end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_depth();
    @(negedge clk);
    we = 1'b1; a = 8'hF0; d = 32'h1111_1111; wstrb = 4'hF;
    @(negedge clk);
    checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL oob_write_err got=%b exp=1", err2); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL inrange_write_err got=%b exp=0", err0); end
    @(negedge clk);
    we = 1'b0;
    checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL oob_err_consecutive got=%b exp=1", err2); end
    @(negedge clk);
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL oob_err_clear got=%b exp=0", err2); end
    rd_addr = {8'h00, 8'hF0};
    #1;
    checks++; if (rd2[31:0] !== 32'h0) begin failures++; $display("FAIL oob_read got=%h exp=0", rd2[31:0]); end
    checks++; if (rd0[31:0] !== 32'h1111_1111) begin failures++; $display("FAIL inrange_read got=%h exp=11111111", rd0[31:0]); end
    @(negedge clk);
    we = 1'b1; a = 8'hC7; d = 32'h0BAD_C0DE;
    @(negedge clk);
    we = 1'b0; rd_addr = {8'h00, 8'hC7};
    #1;
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL last_word_err got=%b exp=0", err2); end
    checks++; if (rd2[31:0] !== 32'h0BAD_C0DE) begin failures++; $display("FAIL last_word_rd got=%h exp=0badc0de", rd2[31:0]); end
  endtask

  task automatic test_rst_mid_clear();
    int n0 = 0;
    @(negedge clk);
    we = 1'b1; a = 8'hF5; d = 32'h5A5A_5A5A; wstrb = 4'hF;
    @(negedge clk);
    we = 1'b0; rd_addr = {8'hF5, 8'hF5};
    #1;
    checks++; if (rd0[31:0] !== 32'h5A5A_5A5A) begin failures++; $display("FAIL pre_reset_word got=%h exp=5a5a5a5a", rd0[31:0]); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy0) n0++;
      if (i == 50) begin
        checks++; if (rd0[31:0] !== 32'h0) begin failures++; $display("FAIL restart_busy_mask got=%h exp=0", rd0[31:0]); end
        checks++; if (rd1[31:0] !== 32'h0) begin failures++; $display("FAIL restart_busy_mask_reg got=%h exp=0", rd1[31:0]); end
      end
      @(negedge clk);
    end
    checks++; if (n0 !== 256) begin failures++; $display("FAIL restart_busy_len got=%0d exp=256", n0); end
    #1;
    checks++; if (rd0[31:0] !== 32'h0) begin failures++; $display("FAIL restart_cleared got=%h exp=0", rd0[31:0]); end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_reg_forward();
    test_comb_read();
    test_depth();
    test_rst_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
